// File: rtl/sync_fifo_prog_if.sv
// Handshake and status bundle for sync_fifo_prog.
// The producer/consumer side uses the master modport; the FIFO uses slave.
interface sync_fifo_prog_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
);
  logic                clr_i;
  logic [DATASIZE-1:0] wdata_i;
  logic                winc_i;
  logic                rinc_i;
  logic [ADDRSIZE:0]   afull_thresh_i;
  logic [ADDRSIZE:0]   aempty_thresh_i;

  logic [DATASIZE-1:0] rdata_o;
  logic                rvalid_o;
  logic [ADDRSIZE:0]   count_o;
  logic                wfull_o;
  logic                rempty_o;
  logic                w_almost_full_o;
  logic                r_almost_empty_o;
  logic                overflow_o;
  logic                underflow_o;

  modport master (
    output clr_i, wdata_i, winc_i, rinc_i, afull_thresh_i, aempty_thresh_i,
    input  rdata_o, rvalid_o, count_o, wfull_o, rempty_o,
           w_almost_full_o, r_almost_empty_o, overflow_o, underflow_o
  );

  modport slave (
    input  clr_i, wdata_i, winc_i, rinc_i, afull_thresh_i, aempty_thresh_i,
    output rdata_o, rvalid_o, count_o, wfull_o, rempty_o,
           w_almost_full_o, r_almost_empty_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, sticky overflow/underflow, synchronous flush and an
// optional first-word-fall-through read port.
// Full/empty come only from the occupancy count, so pointers wrap freely.
module sync_fifo_prog #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4,
  parameter int FWFT     = 0
) (
  input logic             clk_i,
  input logic             rst_ni,
  sync_fifo_prog_if.slave bus
);

  localparam int               DEPTH_I = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] DEPTH  = (ADDRSIZE+1)'(DEPTH_I);

  logic [DATASIZE-1:0] mem [DEPTH_I];
  logic [ADDRSIZE-1:0] wptr;
  logic [ADDRSIZE-1:0] rptr;
  logic [ADDRSIZE:0]   count;
  logic                overflow;
  logic                underflow;

  logic                wfull;
  logic                rempty;
  logic                wr_en;
  logic                rd_en;

  // Occupancy update: a simultaneous push and pop leaves the count unchanged.
  function automatic logic [ADDRSIZE:0] next_count(
    input logic [ADDRSIZE:0] c,
    input logic              wr,
    input logic              rd
  );
    case ({wr, rd})
      2'b10:   next_count = c + (ADDRSIZE+1)'(1);
      2'b01:   next_count = c - (ADDRSIZE+1)'(1);
      default: next_count = c;
    endcase
  endfunction

  // Pointer advance; wraps modulo the depth by construction of the width.
  function automatic logic [ADDRSIZE-1:0] ptr_inc(input logic [ADDRSIZE-1:0] p);
    ptr_inc = p + ADDRSIZE'(1);
  endfunction

  assign wfull  = (count == DEPTH);
  assign rempty = (count == '0);

  // Acceptance looks only at the registered flags, so a pop in the same
  // cycle never makes room for a push into a full FIFO (and vice versa).
  // Reset and flush cycles accept nothing, so memory is left untouched.
  assign wr_en = rst_ni & ~bus.clr_i & bus.winc_i & ~wfull;
  assign rd_en = rst_ni & ~bus.clr_i & bus.rinc_i & ~rempty;

  assign bus.count_o          = count;
  assign bus.wfull_o          = wfull;
  assign bus.rempty_o         = rempty;
  assign bus.w_almost_full_o  = (count >= bus.afull_thresh_i);
  assign bus.r_almost_empty_o = (count <= bus.aempty_thresh_i);
  assign bus.overflow_o       = overflow;
  assign bus.underflow_o      = underflow;

  // Control state: pointers, occupancy and sticky error flags.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || bus.clr_i) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en) wptr <= ptr_inc(wptr);
      if (rd_en) rptr <= ptr_inc(rptr);
      count <= next_count(count, wr_en, rd_en);
      if (bus.winc_i && wfull)  overflow  <= 1'b1;
      if (bus.rinc_i && rempty) underflow <= 1'b1;
    end
  end

  // Storage array; contents survive reset and flush.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wptr] <= bus.wdata_i;
  end

  if (FWFT != 0) begin : g_fwft
    // Head of queue is always visible; valid whenever anything is stored.
    assign bus.rdata_o  = mem[rptr];
    assign bus.rvalid_o = ~rempty;
  end else begin : g_std
    logic [DATASIZE-1:0] rdata_p1;
    logic                vld_p1;

    // ---- stage p1: registered read, one cycle after the accepted pop ----
    always_ff @(posedge clk_i) begin
      if (!rst_ni || bus.clr_i) begin
        rdata_p1 <= '0;
        vld_p1   <= 1'b0;
      end else begin
        vld_p1 <= rd_en;
        if (rd_en) rdata_p1 <= mem[rptr];
      end
    end

    assign bus.rdata_o  = rdata_p1;
    assign bus.rvalid_o = vld_p1;
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a standard-read and an FWFT instance share one
// stimulus stream; a queue model predicts every output each cycle, and
// directed literal expectations pin key points of the scenario.
module tb_sync_fifo_prog;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          clr;
  logic          winc;
  logic          rinc;
  logic [DW-1:0] wdata;
  logic [AW:0]   afull;
  logic [AW:0]   aempty;

  sync_fifo_prog_if #(.DATASIZE(DW), .ADDRSIZE(AW)) b0 ();
  sync_fifo_prog_if #(.DATASIZE(DW), .ADDRSIZE(AW)) b1 ();

  assign b0.clr_i = clr;   assign b1.clr_i = clr;
  assign b0.wdata_i = wdata; assign b1.wdata_i = wdata;
  assign b0.winc_i = winc; assign b1.winc_i = winc;
  assign b0.rinc_i = rinc; assign b1.rinc_i = rinc;
  assign b0.afull_thresh_i = afull;   assign b1.afull_thresh_i = afull;
  assign b0.aempty_thresh_i = aempty; assign b1.aempty_thresh_i = aempty;

  sync_fifo_prog #(.DATASIZE(DW), .ADDRSIZE(AW), .FWFT(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(b0)
  );
  sync_fifo_prog #(.DATASIZE(DW), .ADDRSIZE(AW), .FWFT(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(b1)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  // Reference model: contents as a queue plus sticky bits and the
  // registered-read output of the standard port.
  logic [DW-1:0] q[$];
  logic          m_ovf;
  logic          m_udf;
  logic [DW-1:0] m_rd0;
  logic          m_rv0;
  bit            chk_en = 1'b0;

  // Advance the model on each clock edge from the inputs presented to it.
  always @(posedge clk) begin : model
    bit full_b, empty_b;
    if (!rst_n || clr) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_rd0 = '0;
      m_rv0 = 1'b0;
    end else begin
      full_b  = (q.size() == DEPTH);
      empty_b = (q.size() == 0);
      if (winc && full_b)  m_ovf = 1'b1;
      if (rinc && empty_b) m_udf = 1'b1;
      m_rv0 = 1'b0;
      if (rinc && !empty_b) begin
        m_rd0 = q.pop_front();
        m_rv0 = 1'b1;
      end
      if (winc && !full_b) q.push_back(wdata);
    end
  end

  task automatic cmp_status(input string tag, input logic [AW:0] cnt,
                            input logic wf, input logic re, input logic af,
                            input logic ae, input logic ov, input logic un);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(cnt), 32'(n));
    chk({tag, ".wfull"}, 32'(wf), 32'(n == DEPTH));
    chk({tag, ".rempty"}, 32'(re), 32'(n == 0));
    chk({tag, ".afull"}, 32'(af), 32'(n >= int'(afull)));
    chk({tag, ".aempty"}, 32'(ae), 32'(n <= int'(aempty)));
    chk({tag, ".ovf"}, 32'(ov), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(un), 32'(m_udf));
  endtask

  // Mid-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_status("std", b0.count_o, b0.wfull_o, b0.rempty_o, b0.w_almost_full_o,
                 b0.r_almost_empty_o, b0.overflow_o, b0.underflow_o);
      cmp_status("fwft", b1.count_o, b1.wfull_o, b1.rempty_o, b1.w_almost_full_o,
                 b1.r_almost_empty_o, b1.overflow_o, b1.underflow_o);
      chk("std.rvalid", 32'(b0.rvalid_o), 32'(m_rv0));
      chk("std.rdata", 32'(b0.rdata_o), 32'(m_rd0));
      chk("fwft.rvalid", 32'(b1.rvalid_o), 32'(q.size() != 0));
      if (q.size() != 0) chk("fwft.rdata", 32'(b1.rdata_o), 32'(q[0]));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = '0;
    afull = 5'd14; aempty = 5'd2;
    tick; tick;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset state
    chk("rst_rempty", 32'(b0.rempty_o), 1);
    chk("rst_raempty", 32'(b0.r_almost_empty_o), 1);
    chk("rst_wfull", 32'(b0.wfull_o), 0);
    chk("rst_count", 32'(b0.count_o), 0);
    chk("rst_rdata", 32'(b0.rdata_o), 0);
    chk("rst_rvalid", 32'(b0.rvalid_o), 0);
    chk("rst_rvalid_fwft", 32'(b1.rvalid_o), 0);

    // Write 0..19 with no reads
    for (int i = 0; i < 20; i++) begin
      winc = 1'b1; wdata = 8'(i);
      tick;
      if (i == 12) chk("afull_13", 32'(b0.w_almost_full_o), 0);
      if (i == 13) chk("afull_14", 32'(b0.w_almost_full_o), 1);
      if (i == 15) begin
        chk("full_count", 32'(b0.count_o), 16);
        chk("full_flag", 32'(b0.wfull_o), 1);
        chk("no_ovf_yet", 32'(b0.overflow_o), 0);
      end
    end
    winc = 1'b0;
    chk("ovf_set", 32'(b0.overflow_o), 1);
    chk("count_sat", 32'(b0.count_o), 16);
    chk("fwft_head", 32'(b1.rdata_o), 0);

    // Read back 16 words
    for (int k = 0; k < 16; k++) begin
      rinc = 1'b1;
      tick;
      chk("rd_data", 32'(b0.rdata_o), 32'(k));
      chk("rd_valid", 32'(b0.rvalid_o), 1);
      if (k == 0) chk("fwft_next", 32'(b1.rdata_o), 1);
    end
    rinc = 1'b0;
    tick;
    chk("rd_valid_drop", 32'(b0.rvalid_o), 0);
    chk("rd_hold", 32'(b0.rdata_o), 15);
    chk("drained", 32'(b0.rempty_o), 1);

    // Flush clears sticky overflow and read data
    clr = 1'b1; tick; clr = 1'b0;
    chk("clr_ovf", 32'(b0.overflow_o), 0);
    chk("clr_rdata", 32'(b0.rdata_o), 0);

    // FWFT: word into empty FIFO shows without a pop
    winc = 1'b1; wdata = 8'hA5; tick; winc = 1'b0;
    chk("fwft_a5", 32'(b1.rdata_o), 32'h A5);
    chk("fwft_a5_vld", 32'(b1.rvalid_o), 1);
    rinc = 1'b1; tick; rinc = 1'b0;
    chk("fwft_pop_empty", 32'(b1.rempty_o), 1);
    chk("fwft_pop_vld", 32'(b1.rvalid_o), 0);
    chk("std_a5", 32'(b0.rdata_o), 32'h A5);

    // Streaming at constant occupancy 5, pointers wrap twice
    for (int k = 0; k < 5; k++) begin
      winc = 1'b1; wdata = 8'(8'hC0 + k); tick;
    end
    for (int j = 0; j < 40; j++) begin
      winc = 1'b1; rinc = 1'b1; wdata = 8'(j);
      tick;
      chk("stream_count", 32'(b0.count_o), 5);
      if (j == 0) chk("stream_first", 32'(b0.rdata_o), 32'h C0);
      if (j == 39) begin
        chk("stream_last", 32'(b0.rdata_o), 34);
        chk("stream_fwft_head", 32'(b1.rdata_o), 35);
      end
    end
    winc = 1'b0;
    for (int k = 0; k < 5; k++) tick;
    rinc = 1'b0;
    chk("stream_drain", 32'(b0.rdata_o), 39);
    chk("stream_empty", 32'(b0.rempty_o), 1);

    // Simultaneous push/pop while empty
    winc = 1'b1; rinc = 1'b1; wdata = 8'h3C; tick;
    winc = 1'b0; rinc = 1'b0;
    chk("empty_pair_count", 32'(b0.count_o), 1);
    chk("empty_pair_udf", 32'(b0.underflow_o), 1);
    chk("empty_pair_rv", 32'(b0.rvalid_o), 0);

    for (int k = 1; k < 16; k++) begin
      winc = 1'b1; wdata = 8'(8'h40 + k); tick;
    end
    winc = 1'b0;
    chk("refill_full", 32'(b0.wfull_o), 1);

    // Threshold boundaries
    afull = 5'd17; #1;
    chk("afull_gt_depth", 32'(b0.w_almost_full_o), 0);
    afull = 5'd0; #1;
    chk("afull_zero", 32'(b0.w_almost_full_o), 1);
    afull = 5'd14;

    // Simultaneous push/pop while full
    winc = 1'b1; rinc = 1'b1; wdata = 8'h77; tick;
    winc = 1'b0; rinc = 1'b0;
    chk("full_pair_count", 32'(b0.count_o), 15);
    chk("full_pair_ovf", 32'(b0.overflow_o), 1);
    chk("full_pair_rdata", 32'(b0.rdata_o), 32'h 3C);

    rinc = 1'b1;
    for (int k = 0; k < 6; k++) tick;
    rinc = 1'b0;
    chk("count_nine", 32'(b0.count_o), 9);
    chk("pop6_rdata", 32'(b0.rdata_o), 32'h 46);

    // Flush with a pending write
    clr = 1'b1; winc = 1'b1; wdata = 8'hEE; tick;
    clr = 1'b0; winc = 1'b0;
    chk("clr_count", 32'(b0.count_o), 0);
    chk("clr_rempty", 32'(b0.rempty_o), 1);
    chk("clr_ovf2", 32'(b0.overflow_o), 0);
    chk("clr_udf", 32'(b0.underflow_o), 0);

    winc = 1'b1; wdata = 8'h11; tick; winc = 1'b0;
    chk("after_clr_fwft", 32'(b1.rdata_o), 32'h 11);
    rinc = 1'b1; tick; rinc = 1'b0;
    chk("after_clr_std", 32'(b0.rdata_o), 32'h 11);
    chk("after_clr_count", 32'(b0.count_o), 0);
    tick;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
